// File: rtl/logsys_cpld_slave_pkg.sv
// Shared constants and the status-word builder for the LOGSYS CPLD link responder.
package logsys_cpld_pkg;
  localparam int FRAME_LEN    = 16;
  localparam int ST_DIP_LSB   = 1;
  localparam int ST_NAV_LSB   = 9;
  localparam int ST_REQ_BIT   = 14;
  localparam int LED_W        = 8;
  localparam int NAV_W        = 5;
  localparam int DIP_W        = 8;
  localparam int SEG_W        = 8;
  localparam int BLANK_CYCLES = 16;

  typedef logic [FRAME_LEN-1:0] frame_t;

  function automatic frame_t status_word(input logic [DIP_W-1:0] dip,
                                         input logic [NAV_W-1:0] nav,
                                         input logic             req);
    frame_t w;
    w = '0;
    w[ST_DIP_LSB +: DIP_W] = dip;
    w[ST_NAV_LSB +: NAV_W] = nav;
    w[ST_REQ_BIT]          = req;
    return w;
  endfunction
endpackage

// File: rtl/logsys_cpld_slave_if.sv
// Four-wire serial link between the FPGA SimpleIO master and the CPLD responder.
interface logsys_cpld_slave_if;
  logic cpld_clk;
  logic cpld_load;
  logic cpld_mosi;
  logic cpld_miso;

  modport master (output cpld_clk, output cpld_load, output cpld_mosi, input cpld_miso);
  modport slave  (input cpld_clk, input cpld_load, input cpld_mosi, output cpld_miso);
endinterface

// File: rtl/logsys_cpld_slave_sync.sv
// 2-flop synchronizer with one extra register for edge detection (cpld_sync_edge).
module cpld_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;
endmodule

// File: rtl/logsys_cpld_slave.sv
// LOGSYS CPLD link responder: shifts 16-bit frames, drives LEDs and a 2-digit muxed display.
// Optional link watchdog enabled by defining CPLD_LINK_WDT_EN.
module logsys_cpld_slave
  import logsys_cpld_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int MUX_DIV     = 16000,
  parameter int WDT_CYCLES  = 160000
) (
  input  logic              clk,
  input  logic              rst,
  logsys_cpld_slave_if.slave lnk,
  input  logic [DIP_W-1:0]  dipsw,
  input  logic [NAV_W-1:0]  navsw,
  output logic [LED_W-1:0]  led,
  output logic [SEG_W-1:0]  seg,
  output logic [1:0]        dig_en,
  output logic              link_ok
);
  localparam int CNT_W = $clog2(MUX_DIV);
  // Clock rate only matters as an oversampling bound on the link; nothing derives from it.
  localparam int unused_clk_freq_hz = CLK_FREQ_HZ;

  logic clk_s, clk_rise, clk_fall;
  logic load_s, mosi_s;
  logic [DIP_W-1:0] dip_s;
  logic [NAV_W-1:0] nav_s;
  logic [DIP_W+NAV_W+1:0] lvl_rise_unused, lvl_fall_unused;
  logic clk_s_unused;

  cpld_sync_edge #(.W(1)) u_clk_sync (
    .clk(clk), .rst(rst), .d(lnk.cpld_clk),
    .level(clk_s), .rise(clk_rise), .fall(clk_fall)
  );

  cpld_sync_edge #(.W(DIP_W+NAV_W+2)) u_lvl_sync (
    .clk(clk), .rst(rst), .d({lnk.cpld_load, lnk.cpld_mosi, dipsw, navsw}),
    .level({load_s, mosi_s, dip_s, nav_s}),
    .rise(lvl_rise_unused), .fall(lvl_fall_unused)
  );
  assign clk_s_unused = clk_s;

  frame_t rx_q, rx_d, tx_q, tx_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SEG_W-1:0] disp1_q, disp1_d, disp2_q, disp2_d, seg_q, seg_d;
  logic [1:0] dig_en_q, dig_en_d;
  logic req_sel_q, req_sel_d, link_ok_q, link_ok_d, miso_q, miso_d, slot_q, slot_d;
  logic [CNT_W-1:0] mux_cnt_q, mux_cnt_d;
`ifdef CPLD_LINK_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
`endif

  always_comb begin
    rx_d      = rx_q;
    tx_d      = tx_q;
    led_d     = led_q;
    disp1_d   = disp1_q;
    disp2_d   = disp2_q;
    req_sel_d = req_sel_q;
    link_ok_d = link_ok_q;
    miso_d    = tx_q[0];
    mux_cnt_d = mux_cnt_q;
    slot_d    = slot_q;
`ifdef CPLD_LINK_WDT_EN
    wdt_d = wdt_q;
    if (clk_rise || clk_fall) begin
      wdt_d = '0;
    end else if (wdt_q != WDT_W'(WDT_CYCLES)) begin
      wdt_d = wdt_q + 1'b1;
    end
    // A stalled link blanks the board; a later load edge below overrides this.
    if (wdt_q == WDT_W'(WDT_CYCLES)) begin
      link_ok_d = 1'b0;
      led_d     = '0;
      disp1_d   = '0;
      disp2_d   = '0;
      req_sel_d = 1'b0;
    end
`endif

    if (clk_rise) begin
      rx_d = {mosi_s, rx_q[FRAME_LEN-1:1]};
    end

    if (clk_fall) begin
      if (!load_s) begin
        tx_d = {1'b0, tx_q[FRAME_LEN-1:1]};
      end else begin
        led_d = rx_q[LED_W-1:0];
        if (req_sel_q) begin
          disp1_d = rx_q[FRAME_LEN-1:LED_W];
        end else begin
          disp2_d = rx_q[FRAME_LEN-1:LED_W];
        end
        req_sel_d = ~req_sel_q;
        tx_d      = status_word(dip_s, nav_s, ~req_sel_q);
        link_ok_d = 1'b1;
      end
    end

    if (mux_cnt_q == CNT_W'(MUX_DIV - 1)) begin
      mux_cnt_d = '0;
      slot_d    = ~slot_q;
    end else begin
      mux_cnt_d = mux_cnt_q + 1'b1;
    end

    // Digit enables stay off at the start of each slot so the old segments never ghost.
    if (mux_cnt_q < CNT_W'(BLANK_CYCLES)) begin
      dig_en_d = 2'b00;
    end else begin
      dig_en_d = slot_q ? 2'b10 : 2'b01;
    end
    seg_d = slot_q ? disp2_q : disp1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= '0;
      tx_q      <= '0;
      led_q     <= '0;
      disp1_q   <= '0;
      disp2_q   <= '0;
      seg_q     <= '0;
      dig_en_q  <= '0;
      req_sel_q <= 1'b0;
      link_ok_q <= 1'b0;
      miso_q    <= 1'b0;
      slot_q    <= 1'b0;
      mux_cnt_q <= '0;
`ifdef CPLD_LINK_WDT_EN
      wdt_q     <= '0;
`endif
    end else begin
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      led_q     <= led_d;
      disp1_q   <= disp1_d;
      disp2_q   <= disp2_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      req_sel_q <= req_sel_d;
      link_ok_q <= link_ok_d;
      miso_q    <= miso_d;
      slot_q    <= slot_d;
      mux_cnt_q <= mux_cnt_d;
`ifdef CPLD_LINK_WDT_EN
      wdt_q     <= wdt_d;
`endif
    end
  end

  assign lnk.cpld_miso = miso_q;
  assign led           = led_q;
  assign seg           = seg_q;
  assign dig_en        = dig_en_q;
  assign link_ok       = link_ok_q;
endmodule

// File: tb/tb_logsys_cpld_slave.sv
// Scoreboard bench for logsys_cpld_slave: bit-banged frames at ratio 16 against a frame-level model.
module tb_logsys_cpld_slave;
  localparam int MUX_DIV = 200;
  localparam int WDT     = 2000;
  localparam int HALF    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] dipsw = '0;
  logic [4:0] navsw = '0;
  logic [7:0] led, seg;
  logic [1:0] dig_en;
  logic link_ok;

  logsys_cpld_slave_if lnk();

  logsys_cpld_slave #(.CLK_FREQ_HZ(16000000), .MUX_DIV(MUX_DIV), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .lnk(lnk), .dipsw(dipsw), .navsw(navsw),
    .led(led), .seg(seg), .dig_en(dig_en), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  led;
    logic        lok;
    logic [15:0] miso;
    logic [7:0]  d1;
    logic [7:0]  d2;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic        m_req, m_lok;
  logic [7:0]  m_led, m_d1, m_d2;
  logic [15:0] m_tx;
  logic [15:0] miso_acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_lok = 1'b0; m_led = '0; m_d1 = '0; m_d2 = '0; m_tx = '0;
  endtask

  // Frame-level expectation: what the board shows after the load edge, and what
  // the FPGA reads back during this frame (the status captured at the previous load).
  task automatic model_frame(input logic [15:0] w);
    exp_t e;
    e.miso = m_tx;
    m_led  = w[7:0];
    if (m_req) m_d1 = w[15:8];
    else       m_d2 = w[15:8];
    m_req = ~m_req;
    m_tx  = (16'(dipsw) << 1) | (16'(navsw) << 9) | (16'(m_req) << 14);
    m_lok = 1'b1;
    e.led = m_led; e.lok = m_lok; e.d1 = m_d1; e.d2 = m_d2;
    sb.push_back(e);
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits, input bit do_load);
    if (do_load) model_frame(w);
    for (int i = 0; i < nbits; i++) begin
      lnk.cpld_mosi = w[i];
      cyc(HALF);
      lnk.cpld_clk = 1'b1;
      if (do_load && i == nbits - 1) lnk.cpld_load = 1'b1;
      cyc(HALF);
      lnk.cpld_clk = 1'b0;
    end
    cyc(HALF);
    lnk.cpld_load = 1'b0;
    cyc(HALF);
  endtask

  task automatic frame(input logic [15:0] w);
    send_bits(w, 16, 1'b1);
    cyc(6 * MUX_DIV);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_seg"}, seg, 0);
    chk({tag, "_dig_en"}, dig_en, 0);
    chk({tag, "_miso"}, lnk.cpld_miso, 0);
    chk({tag, "_link_ok"}, link_ok, 0);
  endtask

  // The FPGA samples miso on each rising link clock.
  always @(posedge lnk.cpld_clk) miso_acc = {lnk.cpld_miso, miso_acc[15:1]};

  task automatic wait_dig(input logic [1:0] v, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (dig_en !== v && n < 3 * MUX_DIV) begin
      @(negedge clk);
      n++;
    end
    if (dig_en !== v) begin
      ok = 1'b0;
      chk("dig_en_timeout", dig_en, v);
    end
  endtask

  task automatic chk_slot(input logic [1:0] from_en, input logic [1:0] to_en,
                          input logic [7:0] exp_seg, input string tag);
    bit ok;
    int blank;
    wait_dig(from_en, ok);
    if (!ok) return;
    wait_dig(2'b00, ok);
    if (!ok) return;
    blank = 0;
    while (dig_en === 2'b00 && blank < 100) begin
      @(negedge clk);
      blank++;
    end
    chk({tag, "_blank_len"}, blank, 16);
    chk({tag, "_dig_en"}, dig_en, to_en);
    chk({tag, "_seg"}, seg, exp_seg);
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] got_miso;
    forever begin
      @(negedge lnk.cpld_clk);
      if (lnk.cpld_load === 1'b1) begin
        got_miso = miso_acc;
        repeat (8) @(negedge clk);
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("led", led, e.led);
          chk("link_ok", link_ok, e.lok);
          chk("miso_word", got_miso, e.miso);
          chk_slot(2'b01, 2'b10, e.d2, "digit2");
          chk_slot(2'b10, 2'b01, e.d1, "digit1");
        end
      end
    end
  end

  initial begin : stimulus
    lnk.cpld_clk  = 1'b0;
    lnk.cpld_load = 1'b0;
    lnk.cpld_mosi = 1'b0;
    model_reset();
    cyc(5);
    chk_reset_outputs("por");
    rst = 1'b0;
    cyc(20);

    dipsw = 8'h81; navsw = 5'h15;
    frame(16'h3CA5);
    frame(16'h7F00);

    for (int k = 0; k < 10; k++) begin
      dipsw = 8'($urandom);
      navsw = 5'($urandom);
      frame(16'($urandom));
    end

    send_bits(16'h5A5A, 7, 1'b0);
    rst = 1'b1;
    cyc(4);
    chk_reset_outputs("midframe_rst");
    rst = 1'b0;
    model_reset();
    cyc(20);
    dipsw = 8'h3C; navsw = 5'h0A;
    frame(16'h00FF);
    frame(16'h1234);

    cyc(WDT + 5);
`ifdef CPLD_LINK_WDT_EN
    m_led = '0; m_d1 = '0; m_d2 = '0; m_req = 1'b0; m_lok = 1'b0;
`endif
    chk("stall_led", led, m_led);
    chk("stall_link_ok", link_ok, m_lok);
    frame(16'hC3E7);
    dipsw = 8'($urandom); navsw = 5'($urandom);
    frame(16'($urandom));

    cyc(1500);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
